divider_32by16: RTL and testbench
=================================

DIVIDER_32BY16 -- requirements
Module: divider_32by16

Interface
REQ-001 SHALL have parameter N_W, default 32, dividend and quotient width; only the default is verified.
REQ-002 SHALL have parameter D_W, default 16, divisor and remainder width; only the default is verified.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port START  input  1  request pulse; operands sampled with it.
REQ-006 SHALL have port N  input  32  dividend, unsigned.
REQ-007 SHALL have port D  input  16  divisor, unsigned.
REQ-008 SHALL have port BUSY  output  1  division in progress.
REQ-009 SHALL have port DONE  output  1  one-cycle result-valid strobe.
REQ-010 SHALL have port Q  output  32  quotient, floor(N/D).
REQ-011 SHALL have port R  output  16  remainder, N mod D.
REQ-012 SHALL have port DIV0  output  1  set with DONE when the latched D was zero.

Function
REQ-013 SHALL implement unsigned restoring division, one quotient bit per clock, MSB first, with a 17-bit partial remainder so no intermediate overflows.
REQ-014 SHALL use FSM states IDLE, RUN and FIN; IDLE->RUN on START; RUN->FIN when the bit counter reaches 0 after 32 iterations; FIN->IDLE unconditionally.
REQ-015 SHALL latch N and D at the edge where START=1 in IDLE (edge k); later changes on N and D SHALL NOT affect the result.
REQ-016 SHALL perform the 32 iterations on edges k+1..k+32; SHALL update Q, R and DIV0 and raise DONE at edge k+33; DONE SHALL be high for exactly one cycle.
REQ-017 SHALL drive BUSY high from edge k through the cycle in which DONE is high, and low otherwise.
REQ-018 SHALL ignore START while BUSY=1, including in the DONE cycle; a START sampled in IDLE on the edge that deasserts DONE SHALL be accepted.
REQ-019 SHALL hold Q, R and DIV0 stable from DONE until the next DONE.
REQ-020 SHALL, when the latched D=0, keep the same 33-cycle latency and produce Q=32'hFFFFFFFF, R=N[15:0] and DIV0=1; DIV0 SHALL be 0 for any D!=0.
REQ-021 SHALL satisfy Q*D+R==N and R<D for every D!=0, including Q values wider than 16 bits (N[31:16]>=D).

Reset
REQ-022 SHALL, while RST_N=0, force IDLE, BUSY=0, DONE=0, Q=0, R=0, DIV0=0, the counter to 0 and the operand registers to 0, asynchronously.
REQ-023 SHALL, on reset mid-division, abort with no DONE; the first START after RST_N rises SHALL behave exactly as in REQ-015..016.

Structure
REQ-024 SHALL take the FSM state enumeration, N_W, D_W and the iteration count (32) from a shared package rsa_div_pkg.
REQ-025 SHALL place the single restoring step (shift-in, trial subtract, select, quotient bit) in a combinational sub-module div_step, instantiated once.
REQ-026 SHALL keep all registers in divider_32by16 only and SHALL have no combinational path from START, N or D to any output.

Verification
REQ-027 SHALL cover this case: N=100000, D=7, one START -> DONE exactly 33 cycles later, Q=14285, R=5, DIV0=0, BUSY high for 34 cycles.
REQ-028 SHALL cover this case: N=32'hFFFFFFFF, D=16'hFFFF -> Q=32'h00010001, R=0; and N=5, D=9 -> Q=0, R=5.
REQ-029 SHALL cover this case: D=0, N=32'h1234ABCD -> after 33 cycles Q=32'hFFFFFFFF, R=16'hABCD, DIV0=1.
REQ-030 SHALL cover this case: START for N=50, D=3, then START at cycle 10 with N=99, D=10 -> only Q=16, R=2; the second START is ignored.
REQ-031 SHALL cover this case: RST_N pulsed low at iteration 20 -> outputs 0 immediately, no DONE; a START 2 cycles after release with N=1000, D=10 -> Q=100, R=0.
REQ-032 SHALL cover this case: 2000 random back-to-back operations with START issued in each DONE-following cycle -> Q*D+R==N and R<D every time, checked by also driving Q[15:0] and D through Multiplier_16bit when Q<65536.

Source files
------------

// File: rtl/rsa_div_pkg.sv
// -----------------------------------------------------------------------------
// rsa_div_pkg
//   Shared definitions for the 32-by-16 restoring divider:
//     N_W    - dividend / quotient width
//     D_W    - divisor / remainder width
//     ITERS  - number of restoring iterations (one quotient bit each)
//     CNT_W  - width of the iteration down-counter
//     state_e- divider control FSM encoding
// -----------------------------------------------------------------------------
package rsa_div_pkg;

  localparam int N_W   = 32;
  localparam int D_W   = 16;
  localparam int ITERS = 32;
  localparam int CNT_W = $clog2(ITERS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage : rsa_div_pkg

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One combinational restoring-division step.
//   The partial remainder is shifted left by one with the next dividend bit,
//   giving a D_W+1 bit value that cannot overflow; the divisor is trial-
//   subtracted and the difference is kept only when it did not go negative.
//
//   Ports
//     rem_i  : current partial remainder (always < divisor when divisor != 0)
//     bit_i  : next dividend bit, MSB first
//     div_i  : divisor
//     rem_o  : next partial remainder
//     qbit_o : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int D_W = 16
) (
  input  logic [D_W-1:0] rem_i,
  input  logic           bit_i,
  input  logic [D_W-1:0] div_i,
  output logic [D_W-1:0] rem_o,
  output logic           qbit_o
);

  logic [D_W:0] shift;
  logic [D_W:0] trial;

  assign shift  = {rem_i, bit_i};
  assign trial  = shift - {1'b0, div_i};
  assign qbit_o = (shift >= {1'b0, div_i});

  // When the subtract succeeds the result is < divisor, so it fits in D_W bits.
  // With a zero divisor every step "succeeds" and the remainder simply shifts
  // the dividend through, ending as its low D_W bits.
  assign rem_o  = qbit_o ? trial[D_W-1:0] : shift[D_W-1:0];

endmodule : div_step

// File: rtl/divider_32by16.sv
// -----------------------------------------------------------------------------
// divider_32by16
//   Sequential unsigned restoring divider, one quotient bit per clock.
//
//   Timing (edge k = edge where START is sampled in IDLE):
//     k        : operands latched, BUSY rises
//     k+1..k+32: 32 restoring iterations (RUN)
//     k+33     : Q/R/DIV0 updated, DONE pulses for one cycle (FIN -> IDLE)
//     k+34     : BUSY falls unless a new START is sampled on this edge
//
//   Ports
//     CLK   : clock, rising edge
//     RST_N : asynchronous active-low reset
//     START : request pulse, operands sampled with it (ignored while busy)
//     N     : dividend, unsigned
//     D     : divisor, unsigned
//     BUSY  : division in progress (includes the DONE cycle)
//     DONE  : one-cycle result-valid strobe
//     Q     : quotient, floor(N/D)  (all ones when D == 0)
//     R     : remainder, N mod D    (N[D_W-1:0] when D == 0)
//     DIV0  : flags a zero divisor, valid with DONE
//
//   All outputs are registered; START/N/D only reach state registers.
// -----------------------------------------------------------------------------
module divider_32by16 #(
  parameter int N_W = rsa_div_pkg::N_W,
  parameter int D_W = rsa_div_pkg::D_W
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           START,
  input  logic [N_W-1:0] N,
  input  logic [D_W-1:0] D,
  output logic           BUSY,
  output logic           DONE,
  output logic [N_W-1:0] Q,
  output logic [D_W-1:0] R,
  output logic           DIV0
);

  import rsa_div_pkg::*;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  // Dividend bits shift out of the MSB while quotient bits shift in at the
  // LSB, so after ITERS steps this register holds the quotient.
  logic [N_W-1:0]   nq_q;
  logic [D_W-1:0]   rem_q;
  logic [D_W-1:0]   d_q;
  logic             busy_q;
  logic             done_q;
  logic [N_W-1:0]   q_q;
  logic [D_W-1:0]   r_q;
  logic             div0_q;

  logic [D_W-1:0]   rem_d;
  logic             qbit_d;

  div_step #(
    .D_W (D_W)
  ) u_step (
    .rem_i  (rem_q),
    .bit_i  (nq_q[N_W-1]),
    .div_i  (d_q),
    .rem_o  (rem_d),
    .qbit_o (qbit_d)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nq_q    <= '0;
      rem_q   <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      div0_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // IDLE is also the DONE cycle: BUSY stays up only if a new request
          // arrives back-to-back.
          busy_q <= START;
          if (START) begin
            nq_q    <= N;
            d_q     <= D;
            rem_q   <= '0;
            cnt_q   <= CNT_W'(ITERS);
            state_q <= RUN;
          end
        end
        RUN: begin
          nq_q  <= {nq_q[N_W-2:0], qbit_d};
          rem_q <= rem_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= FIN;
        end
        FIN: begin
          q_q     <= nq_q;
          r_q     <= rem_q;
          div0_q  <= (d_q == '0);
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign Q    = q_q;
  assign R    = r_q;
  assign DIV0 = div0_q;

endmodule : divider_32by16

// File: tb/tb_divider_32by16.sv
// -----------------------------------------------------------------------------
// tb_divider_32by16
//   Scoreboard bench: every accepted request pushes its expected result, the
//   DONE monitor pops and compares. Inputs change and outputs are sampled on
//   the falling edge.
// -----------------------------------------------------------------------------
module tb_divider_32by16;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic [31:0] N;
  logic [15:0] D;
  logic        BUSY;
  logic        DONE;
  logic [31:0] Q;
  logic [15:0] R;
  logic        DIV0;

  typedef struct packed {
    logic [31:0] n;
    logic [15:0] d;
    logic [31:0] q;
    logic [15:0] r;
    logic        div0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic prev_done = 1'b0;
  int   errs = 0;
  int   nchk = 0;

  divider_32by16 dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .N     (N),
    .D     (D),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .Q     (Q),
    .R     (R),
    .DIV0  (DIV0)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] n, input logic [15:0] d);
    exp_t e;
    e.n = n;
    e.d = d;
    if (d == 16'd0) begin
      e.q    = 32'hFFFF_FFFF;
      e.r    = n[15:0];
      e.div0 = 1'b1;
    end else begin
      e.q    = n / {16'd0, d};
      e.r    = 16'(n % {16'd0, d});
      e.div0 = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [15:0] rand_d();
    if ($urandom_range(0, 3) == 0) return 16'($urandom_range(1, 255));
    if ($urandom_range(0, 31) == 0) return 16'd0;
    return 16'($urandom);
  endfunction

  // DONE monitor: pops the scoreboard and checks the result plus the
  // arithmetic identity for nonzero divisors.
  always @(negedge CLK) begin
    if (RST_N && DONE) begin
      chk("done_single_cycle", prev_done, 1'b0);
      if (sb.size() == 0) begin
        chk("spurious_done", 1'b1, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        chk("q", Q, mon_e.q);
        chk("r", R, mon_e.r);
        chk("div0", DIV0, mon_e.div0);
        if (mon_e.d != 16'd0) begin
          chk("q_times_d_plus_r", 64'(Q) * 64'(mon_e.d) + 64'(R), 64'(mon_e.n));
          chk("r_lt_d", 64'(R < mon_e.d), 64'd1);
        end
      end
    end
    prev_done = DONE;
  end

  // Waits for DONE; deasserts START on the first cycle and scrambles the
  // operand inputs every cycle so late operand changes would show up.
  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    do begin
      @(negedge CLK);
      START = 1'b0;
      N     = $urandom;
      D     = 16'($urandom);
      lat++;
      if (BUSY) bc++;
    end while (!DONE && lat < 60);
    if (!DONE) chk("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_op(input logic [31:0] n, input logic [15:0] d);
    int lat, bc;
    @(negedge CLK);
    START = 1'b1;
    N     = n;
    D     = d;
    sb.push_back(model(n, d));
    wait_done(lat, bc);
    // lat counts falling edges after the start edge, so edges = lat-1
    chk("latency", 64'(lat - 1), 64'd33);
    chk("busy_cycles", 64'(bc), 64'd34);
  endtask

  initial begin
    int lat, bc;
    logic [31:0] rn;
    logic [15:0] rd;

    RST_N = 1'b0;
    START = 1'b0;
    N     = '0;
    D     = '0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_q", Q, 32'd0);
    chk("rst_r", R, 16'd0);
    chk("rst_div0", DIV0, 1'b0);
    RST_N = 1'b1;

    // basic case, then hold/idle checks
    do_op(32'd100000, 16'd7);
    chk("c1_q", Q, 32'd14285);
    chk("c1_r", R, 16'd5);
    chk("c1_div0", DIV0, 1'b0);
    @(negedge CLK);
    chk("c1_busy_low", BUSY, 1'b0);
    chk("c1_done_low", DONE, 1'b0);
    repeat (3) @(negedge CLK);
    chk("c1_q_hold", Q, 32'd14285);
    chk("c1_r_hold", R, 16'd5);

    // boundary operands
    do_op(32'hFFFF_FFFF, 16'hFFFF);
    chk("max_q", Q, 32'h0001_0001);
    chk("max_r", R, 16'd0);
    do_op(32'd5, 16'd9);
    chk("small_q", Q, 32'd0);
    chk("small_r", R, 16'd5);
    do_op(32'h1234_ABCD, 16'd0);
    chk("div0_q", Q, 32'hFFFF_FFFF);
    chk("div0_r", R, 16'hABCD);
    chk("div0_flag", DIV0, 1'b1);

    // START while busy is ignored, including on the edge that raises DONE
    @(negedge CLK);
    START = 1'b1;
    N     = 32'd50;
    D     = 16'd3;
    sb.push_back(model(32'd50, 16'd3));
    for (int c = 1; c <= 80; c++) begin
      @(negedge CLK);
      if (DONE) begin
        chk("ign_q", Q, 32'd16);
        chk("ign_r", R, 16'd2);
      end
      START = (c == 10) || (c == 33);
      N     = 32'd99;
      D     = 16'd10;
    end
    START = 1'b0;
    chk("ign_sb_empty", 64'(sb.size()), 64'd0);

    // reset mid-division aborts without DONE
    @(negedge CLK);
    START = 1'b1;
    N     = 32'd100000;
    D     = 16'd7;
    sb.push_back(model(32'd100000, 16'd7));
    @(negedge CLK);
    START = 1'b0;
    repeat (20) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_busy", BUSY, 1'b0);
    chk("mid_rst_done", DONE, 1'b0);
    chk("mid_rst_q", Q, 32'd0);
    chk("mid_rst_r", R, 16'd0);
    sb.delete();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    do_op(32'd1000, 16'd10);
    chk("post_rst_q", Q, 32'd100);
    chk("post_rst_r", R, 16'd0);

    // back-to-back random operations, START in each DONE cycle
    @(negedge CLK);
    rn    = $urandom;
    rd    = rand_d();
    START = 1'b1;
    N     = rn;
    D     = rd;
    sb.push_back(model(rn, rd));
    for (int i = 0; i < 2000; i++) begin
      wait_done(lat, bc);
      chk("b2b_latency", 64'(lat - 1), 64'd33);
      if (i < 1999) begin
        rn    = $urandom;
        rd    = rand_d();
        START = 1'b1;
        N     = rn;
        D     = rd;
        sb.push_back(model(rn, rd));
      end
    end
    @(negedge CLK);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    chk("final_busy_low", BUSY, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule : tb_divider_32by16
